arbitro_somador: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit adder/subtractor datapath among N_REQ requesters.
- Each requester presents operands plus an add/sub select over a valid/ready handshake.
- The block grants one requester, latches its operands and drives the shared unit for one cycle.
- It returns the registered result tagged with the requester id over a valid/ready result channel.
- One operation is in flight at a time.

---
 rtl/arbitro_somador.sv | 142 ++++++++++++++
 tb/tb_arbitro_somador.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_somador.sv
// Round-robin arbiter that shares one WIDTH-bit adder/subtractor among N_REQ
// requesters; one operation in flight, result returned over valid/ready.
module arbitro_somador #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_cout,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    localparam int CW = ID_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_OUT
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   w_gnt;
    logic              w_found;
    logic [CW-1:0]     w_cand;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sub;
    logic [WIDTH-1:0]  w_b_op;
    logic [WIDTH:0]    w_sum;

    logic              r_res_valid;
    logic [WIDTH-1:0]  r_res_data;
    logic              r_res_cout;
    logic [ID_W-1:0]   r_res_id;
    logic [CNT_W-1:0]  r_op_count;

    // Search starts just after the last grant and wraps; the winner drops to lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = CW'(r_last) + CW'(k);
            if (w_cand >= CW'(N_REQ))
                w_cand = w_cand - CW'(N_REQ);
            if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // req_ready is gated by rst_n so it reads zero the instant reset asserts.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_gnt] = rst_n;
                    w_next           = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_OUT;
            S_OUT:   if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction as A + ~B + 1, so the carry out means "no borrow".
    assign w_b_op = r_sub ? ~r_b : r_b;
    assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, r_sub};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= ID_W'(N_REQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a    <= req_a[w_gnt*WIDTH +: WIDTH];
                        r_b    <= req_b[w_gnt*WIDTH +: WIDTH];
                        r_sub  <= req_sub[w_gnt];
                        r_last <= w_gnt;
                    end
                end
                S_EXEC: begin
                    r_res_data  <= w_sum[WIDTH-1:0];
                    r_res_cout  <= w_sum[WIDTH];
                    r_res_id    <= r_last;
                    r_res_valid <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;
    assign op_count  = r_op_count;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_arbitro_somador.sv
// Self-checking bench for arbitro_somador: directed table, round-robin,
// backpressure, reset-mid-op and randomized ops against a behavioural model.
module tb_arbitro_somador;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CN = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_sub;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic            res_cout;
    logic [1:0]      res_id;
    logic            busy;
    logic [CN-1:0]   op_count;

    arbitro_somador #(.N_REQ(N), .WIDTH(W), .CNT_W(CN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_id(res_id),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int model_last = N - 1;
    int model_count = 0;
    int g_last = -1;
    int g_prev = -1;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        bit         sub;
        int         hold;
        logic [7:0] d;
        bit         c;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nxt(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Plain unsigned arithmetic: returns {cout, data}.
    function automatic logic [8:0] ref_op(input logic [N*W-1:0] af, input logic [N*W-1:0] bf,
                                          input logic [N-1:0] s, input int id);
        int a, b, r;
        logic [8:0] o;
        a = int'(af[id*W +: W]);
        b = int'(bf[id*W +: W]);
        if (s[id]) begin
            r = a - b;
            if (r < 0) r = r + 256;
            o = {(a >= b), 8'(r)};
        end else begin
            r = a + b;
            o = {(r > 255), 8'(r % 256)};
        end
        return o;
    endfunction

    // Called just after a clock edge with the DUT in IDLE; returns likewise.
    task automatic run_op(input logic [N-1:0] mask, input logic [N*W-1:0] af,
                          input logic [N*W-1:0] bf, input logic [N-1:0] s, input int hold,
                          input int exp_id, input int exp_data, input int exp_cout);
        req_valid = mask;
        req_a     = af;
        req_b     = bf;
        req_sub   = s;
        res_ready = (hold == 0);
        #1;
        chk("grant", req_ready, 32'(1) << exp_id);
        chk("idle_busy", busy, 0);
        g_prev = g_last;
        g_last = cyc;
        model_last = exp_id;
        @(posedge clk); #1;
        chk("exec_busy", busy, 1);
        chk("exec_rvalid", res_valid, 0);
        chk("exec_rdy", req_ready, 0);
        @(posedge clk); #1;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp_data);
        chk("res_cout", res_cout, exp_cout);
        chk("res_id", res_id, exp_id);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, exp_data);
            chk("hold_id", res_id, exp_id);
            chk("hold_rdy", req_ready, 0);
            chk("hold_busy", busy, 1);
            if (h == hold - 1) res_ready = 1'b1;
        end
        @(posedge clk); #1;
        model_count++;
        req_valid = '0;
        chk("done_valid", res_valid, 0);
        chk("done_busy", busy, 0);
        chk("op_count", op_count, 32'(model_count % 65536));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] af, bf;
        logic [N-1:0]   s, m;
        logic [8:0]     r;
        int             id, hold;

        tbl[0] = '{0, 8'd8,    8'd4,    1'b0, 0, 8'd12,   1'b0};
        tbl[1] = '{2, 8'd8,    8'd4,    1'b1, 0, 8'd4,    1'b1};
        tbl[2] = '{2, 8'd2,    8'd1,    1'b1, 0, 8'd1,    1'b1};
        tbl[3] = '{2, 8'h0B,   8'h06,   1'b1, 0, 8'h05,   1'b1};
        tbl[4] = '{2, 8'd64,   8'd32,   1'b1, 5, 8'd32,   1'b1};
        tbl[5] = '{2, 8'h6B,   8'h56,   1'b1, 0, 8'h15,   1'b1};
        tbl[6] = '{2, 8'h00,   8'h00,   1'b1, 0, 8'h00,   1'b1};
        tbl[7] = '{1, 8'd4,    8'd8,    1'b1, 2, 8'hFC,   1'b0};
        tbl[8] = '{3, 8'hFF,   8'h01,   1'b0, 0, 8'h00,   1'b1};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; res_ready = 1'b0;
        #12;
        chk("rst_rvalid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_cout", res_cout, 0);
        chk("rst_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", op_count, 0);
        chk("rst_rdy", req_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            af = {$urandom, $urandom};
            bf = {$urandom, $urandom};
            s  = 4'($urandom);
            af[tbl[i].id*W +: W] = tbl[i].a;
            bf[tbl[i].id*W +: W] = tbl[i].b;
            s[tbl[i].id]         = tbl[i].sub;
            run_op(4'(1 << tbl[i].id), af, bf, s, tbl[i].hold,
                   tbl[i].id, int'(tbl[i].d), int'(tbl[i].c));
        end

        // All four requesting continuously: strict rotation starting at 0.
        af = {8'd40, 8'd30, 8'd20, 8'd10};
        bf = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            r  = ref_op(af, bf, 4'b0000, id);
            run_op(4'hF, af, bf, 4'b0000, 0, id, int'(r[7:0]), int'(r[8]));
        end

        // Requester 1 alone: one grant every 3 cycles.
        for (int k = 0; k < 3; k++) begin
            af = {$urandom, $urandom};
            bf = {$urandom, $urandom};
            r  = ref_op(af, bf, 4'b0010, 1);
            run_op(4'b0010, af, bf, 4'b0010, 0, 1, int'(r[7:0]), int'(r[8]));
            if (k > 0) chk("spacing", g_last - g_prev, 3);
        end

        for (int k = 0; k < 40; k++) begin
            m    = 4'($urandom_range(1, 15));
            af   = {$urandom, $urandom};
            bf   = {$urandom, $urandom};
            s    = 4'($urandom);
            hold = $urandom_range(0, 3);
            id   = nxt(model_last, m);
            r    = ref_op(af, bf, s, id);
            run_op(m, af, bf, s, hold, id, int'(r[7:0]), int'(r[8]));
        end

        // Reset during EXEC discards the operation and restores priority to 0.
        req_valid = 4'b1000;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rvalid", res_valid, 0);
        chk("mid_rst_rdy", req_ready, 0);
        chk("mid_rst_cnt", op_count, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_id", res_id, 0);
        model_last  = N - 1;
        model_count = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        af = {$urandom, $urandom};
        bf = {$urandom, $urandom};
        r  = ref_op(af, bf, 4'b0001, 0);
        run_op(4'b1001, af, bf, 4'b0001, 0, 0, int'(r[7:0]), int'(r[8]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
